router_output_arbiter: RTL and testbench

//   Per-output-port wormhole arbiter for the Dally router family (corner/edge/centre routers).

---
 rtl/router_output_arbiter_pkg.sv | 27 ++
 rtl/router_output_arbiter_rr_pick.sv | 38 +++
 rtl/router_output_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_router_output_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_output_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : router_output_arbiter_pkg
// Description : Shared types and helpers for the router output-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package router_output_arbiter_pkg;

    // The arbiter is built for exactly four requesters (proc + three ports).
    localparam int ARB_NIN    = 4;
    localparam int ARB_FLIT_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef logic [1:0]            port_idx_t;
    typedef logic [ARB_FLIT_W-1:0] flit_t;

    // Index of the input after idx; the 2-bit type wraps 3 -> 0 on its own.
    function automatic port_idx_t next_idx(input port_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_output_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : router_output_arbiter_rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request found scanning ptr, ptr+1, ... modulo NIN.
// Revision    : 1.0 - initial release
// ============================================================================
module router_output_arbiter_rr_pick
    import router_output_arbiter_pkg::*;
#(
    parameter int NIN = ARB_NIN
) (
    input  logic [NIN-1:0] req,
    input  port_idx_t      ptr,
    output logic [NIN-1:0] gnt_onehot,
    output port_idx_t      gnt_idx,
    output logic           any
);

    // Walk the request vector starting at ptr and keep the first hit.
    always_comb begin
        port_idx_t cand;
        gnt_onehot = '0;
        gnt_idx    = ptr;
        any        = 1'b0;
        cand       = ptr;
        for (int k = 0; k < NIN; k++) begin
            cand = ptr + port_idx_t'(k);
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_onehot[gnt_idx] = any;
    end

endmodule
`default_nettype wire

// File: rtl/router_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : router_output_arbiter
// Description : Per-output-port wormhole arbiter. Round-robin grant among four
//               inputs, grant held from head flit to tail flit, credit-based
//               flow control towards the downstream router, one-cycle
//               registered output stage.
//               Optional feature macro ARB_STATS_EN adds per-input 16-bit
//               packet (head-grant) counters on port grant_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module router_output_arbiter
    import router_output_arbiter_pkg::*;
#(
    parameter int N       = 32,
    parameter int NIN     = ARB_NIN,
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic [NIN-1:0]   in_valid,
    input  logic [NIN*N-1:0] in_flit,
    input  logic [NIN-1:0]   in_tail,
    output logic [NIN-1:0]   in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_flit,
    output logic             out_tail,
    input  logic             credit_in,
    output logic [1:0]       grant_id,
    output logic             busy,
    output logic             credit_err
`ifdef ARB_STATS_EN
    ,
    output logic [NIN*16-1:0] grant_cnt
`endif
);

    localparam logic [3:0] CREDIT_FULL = 4'(CREDITS);

    arb_state_e     state_q,      state_d;
    port_idx_t      rr_ptr_q,     rr_ptr_d;
    port_idx_t      owner_q,      owner_d;
    logic [3:0]     credits_q,    credits_d;
    logic           credit_err_q, credit_err_d;
    logic           out_valid_q,  out_valid_d;
    logic [N-1:0]   out_flit_q,   out_flit_d;
    logic           out_tail_q,   out_tail_d;

    logic [NIN-1:0] pick_onehot;
    port_idx_t      pick_idx;
    logic           pick_any;

    logic           can_send;
    logic           accept;
    port_idx_t      sel;
    logic [NIN-1:0] ready_raw;
    logic [N-1:0]   sel_flit;

    assign can_send = (credits_q != 4'd0);

    router_output_arbiter_rr_pick #(
        .NIN        (NIN)
    ) u_rr_pick (
        .req        (in_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    // Arbitration FSM: pick a new owner in IDLE, follow only the owner in LOCK.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        accept    = 1'b0;
        sel       = owner_q;
        ready_raw = '0;
        case (state_q)
            IDLE: begin
                if (can_send && pick_any) begin
                    accept    = 1'b1;
                    sel       = pick_idx;
                    ready_raw = pick_onehot;
                    owner_d   = pick_idx;
                    if (in_tail[pick_idx]) begin
                        rr_ptr_d = next_idx(pick_idx);
                    end else begin
                        state_d  = LOCK;
                    end
                end
            end
            LOCK: begin
                if (can_send && in_valid[owner_q]) begin
                    accept             = 1'b1;
                    ready_raw[owner_q] = 1'b1;
                    if (in_tail[owner_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_flit = in_flit[int'(sel)*N +: N];

    // Credit counter and sticky overflow flag; simultaneous accept and return cancel.
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        case ({accept, credit_in})
            2'b10: credits_d = credits_q - 4'd1;
            2'b01: begin
                if (credits_q == CREDIT_FULL) begin
                    credit_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + 4'd1;
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    // Output stage: register the accepted flit; valid drops when nothing was taken.
    always_comb begin
        out_valid_d = accept;
        out_flit_d  = accept ? sel_flit : out_flit_q;
        out_tail_d  = accept & in_tail[sel];
    end

    // State, credit and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            credits_q    <= CREDIT_FULL;
            credit_err_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            out_tail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
            out_valid_q  <= out_valid_d;
            out_flit_q   <= out_flit_d;
            out_tail_q   <= out_tail_d;
        end
    end

    // in_ready is combinational, so it is gated by reset to read 0 while held.
    assign in_ready   = rst ? ready_raw : '0;
    assign out_valid  = out_valid_q;
    assign out_flit   = out_flit_q;
    assign out_tail   = out_tail_q;
    assign grant_id   = owner_q;
    assign busy       = (state_q == LOCK);
    assign credit_err = credit_err_q;

`ifdef ARB_STATS_EN
    logic head_grant;
    assign head_grant = accept && (state_q == IDLE);

    for (genvar gi = 0; gi < NIN; gi++) begin : g_stats
        logic [15:0] cnt_q, cnt_d;

        // Count head-flit grants to this input; wraps naturally at 16 bits.
        always_comb begin
            cnt_d = cnt_q;
            if (head_grant && (sel == port_idx_t'(gi))) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        // Packet counter register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grant_cnt[gi*16 +: 16] = cnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_output_arbiter
// Description : Self-checking bench for router_output_arbiter with a
//               packet-level reference model and directed scenarios.
//               Stats checks are built when ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_router_output_arbiter;

    localparam int N       = 32;
    localparam int NIN     = 4;
    localparam int CREDITS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NIN-1:0]   in_valid = '0;
    logic [NIN*N-1:0] in_flit = '0;
    logic [NIN-1:0]   in_tail = '0;
    logic             credit_in = 1'b0;
    logic [NIN-1:0]   in_ready;
    logic             out_valid;
    logic [N-1:0]     out_flit;
    logic             out_tail;
    logic [1:0]       grant_id;
    logic             busy;
    logic             credit_err;
`ifdef ARB_STATS_EN
    logic [NIN*16-1:0] grant_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    router_output_arbiter #(.N(N), .NIN(NIN), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .in_tail    (in_tail),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_flit   (out_flit),
        .out_tail   (out_tail),
        .credit_in  (credit_in),
        .grant_id   (grant_id),
        .busy       (busy),
        .credit_err (credit_err)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    int          m_ptr;
    int          m_owner;
    int          m_credits;
    bit          m_locked;
    bit          m_err;
    bit          e_valid;
    logic [31:0] e_flit;
    bit          e_tail;

    function automatic int model_winner();
        if (m_credits == 0) return -1;
        if (m_locked) return in_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NIN; k++) begin
            int i;
            i = (m_ptr + k) % NIN;
            if (in_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int w;
        logic [3:0] r;
        w = model_winner();
        r = 4'b0000;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_credits = CREDITS;
        m_locked = 0; m_err = 0; e_valid = 0; e_flit = '0; e_tail = 0;
    endtask

    initial model_reset();

    // Compare every cycle at the falling edge, then advance the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_in_ready",  in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_flit",  out_flit, 0);
            chk("rst_out_tail",  out_tail, 0);
            chk("rst_grant_id",  grant_id, 0);
            chk("rst_busy",      busy, 0);
            chk("rst_credit_err", credit_err, 0);
            model_reset();
        end else begin
            int w;
            bit acc;
            chk("m_in_ready",   in_ready, model_ready());
            chk("m_out_valid",  out_valid, e_valid);
            if (e_valid) begin
                chk("m_out_flit", out_flit, e_flit);
                chk("m_out_tail", out_tail, e_tail);
            end
            chk("m_grant_id",   grant_id, m_owner);
            chk("m_busy",       busy, m_locked);
            chk("m_credit_err", credit_err, m_err);
            w   = model_winner();
            acc = (w >= 0);
            e_valid = acc;
            if (acc) begin
                e_flit  = in_flit[w*N +: N];
                e_tail  = in_tail[w];
                m_owner = w;
                if (in_tail[w]) begin
                    m_locked = 0;
                    m_ptr    = (w + 1) % NIN;
                end else begin
                    m_locked = 1;
                end
            end
            if (acc && !credit_in)      m_credits--;
            else if (!acc && credit_in) begin
                if (m_credits == CREDITS) m_err = 1;
                else                      m_credits++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = '0; in_tail = '0; credit_in = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    initial begin
        int acc;
        logic [3:0] e4;

        // Reset state with every input requesting.
        in_valid = 4'hF;
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_busy", busy, 0);
        chk("reset_credit_err", credit_err, 0);
        do_reset();

        // 1: three-flit packet on input 2.
        in_valid = 4'b0100; in_tail = 0; in_flit[64 +: 32] = 32'hAAAA_0001;
        #1;
        chk("t1_ready_a", in_ready, 4'b0100);
        chk("t1_busy_before", busy, 0);
        tick(); in_flit[64 +: 32] = 32'hAAAA_0002; #1;
        chk("t1_out_a", out_flit, 32'hAAAA_0001);
        chk("t1_ready_b", in_ready, 4'b0100);
        chk("t1_busy_lock", busy, 1);
        tick(); in_flit[64 +: 32] = 32'hAAAA_0003; in_tail = 4'b0100; #1;
        chk("t1_out_b", out_flit, 32'hAAAA_0002);
        chk("t1_ready_c", in_ready, 4'b0100);
        tick(); in_valid = 0; in_tail = 0; #1;
        chk("t1_out_c", out_flit, 32'hAAAA_0003);
        chk("t1_out_tail", out_tail, 1);
        chk("t1_busy_after", busy, 0);
        chk("t1_grant_id", grant_id, 2);
        tick(); #1;
        chk("t1_out_valid_gap", out_valid, 0);

        // 2: all inputs with single-flit packets, credit returned every cycle.
        do_reset();
        in_valid = 4'hF; in_tail = 4'hF; credit_in = 1'b1;
        for (int i = 0; i < NIN; i++) in_flit[i*N +: N] = 32'h2000_0000 + i;
        for (int k = 0; k < 5; k++) begin
            #1;
            e4 = 4'b0001 << (k % 4);
            chk("t2_ready", in_ready, e4);
            tick(); #1;
            chk("t2_grant_id", grant_id, k % 4);
            chk("t2_out_flit", out_flit, 32'h2000_0000 + (k % 4));
        end
        in_valid = 0; in_tail = 0; credit_in = 0;

        // 3: owner stalls mid-packet while input 0 requests.
        do_reset();
        in_flit[0 +: 32]  = 32'h3000_0000;
        in_flit[32 +: 32] = 32'h3100_0000;
        in_valid = 4'b0010;
        tick(); in_valid = 4'b0001; #1;
        chk("t3_busy", busy, 1);
        chk("t3_ready_gap1", in_ready, 0);
        tick(); #1;
        chk("t3_ready_gap2", in_ready, 0);
        chk("t3_out_valid_gap", out_valid, 0);
        tick(); in_valid = 4'b0011; in_tail = 4'b0011; in_flit[32 +: 32] = 32'h3100_0001; #1;
        chk("t3_ready_owner", in_ready, 4'b0010);
        chk("t3_busy_hold", busy, 1);
        tick(); in_valid = 4'b0001; #1;
        chk("t3_out_tail_flit", out_flit, 32'h3100_0001);
        chk("t3_busy_release", busy, 0);
        chk("t3_ready_in0", in_ready, 4'b0001);
        tick(); in_valid = 0; in_tail = 0; #1;
        chk("t3_grant_id", grant_id, 0);
        chk("t3_out_in0", out_flit, 32'h3000_0000);

        // 4: credit exhaustion on a six-flit packet.
        do_reset();
        in_valid = 4'b0001; in_tail = 0; acc = 0;
        for (int k = 0; k < 8; k++) begin
            in_flit[0 +: 32] = 32'h4000_0000 + acc;
            in_tail[0] = (acc == 5);
            #1;
            if (in_ready[0]) acc++;
            tick();
        end
        chk("t4_accepted_4", acc, 4);
        credit_in = 1'b1; #1;
        chk("t4_ready_starved", in_ready, 0);
        tick(); credit_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_flit[0 +: 32] = 32'h4000_0000 + acc;
            in_tail[0] = (acc == 5);
            #1;
            if (in_ready[0]) acc++;
            tick();
        end
        chk("t4_accepted_5", acc, 5);
        credit_in = 1'b1;
        tick();
        in_flit[0 +: 32] = 32'h4000_0005; in_tail[0] = 1'b1; #1;
        chk("t4_ready_with_credit", in_ready, 4'b0001);
        tick(); credit_in = 1'b0; in_flit[0 +: 32] = 32'h4100_0000; #1;
        chk("t4_credit_unchanged", in_ready, 4'b0001);
        tick(); in_flit[0 +: 32] = 32'h4100_0001; #1;
        chk("t4_credit_empty", in_ready, 0);
        in_valid = 0; in_tail = 0;

        // 5: credit overflow flag, then async reset mid-packet.
        do_reset();
        credit_in = 1'b1;
        tick(); credit_in = 1'b0; #1;
        chk("t5_credit_err_set", credit_err, 1);
        tick(); tick(); #1;
        chk("t5_credit_err_sticky", credit_err, 1);
        in_valid = 4'b0100; in_tail = 0; in_flit[64 +: 32] = 32'h5000_0000;
        tick(); tick(); #1;
        chk("t5_busy_mid", busy, 1);
        #1 rst = 1'b0;
        #1;
        chk("t5_async_in_ready", in_ready, 0);
        chk("t5_async_out_valid", out_valid, 0);
        chk("t5_async_out_flit", out_flit, 0);
        chk("t5_async_out_tail", out_tail, 0);
        chk("t5_async_grant_id", grant_id, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_credit_err", credit_err, 0);
        tick(); tick();
        rst = 1'b1; in_valid = 4'b0010; in_tail = 0; acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_flit[32 +: 32] = 32'h5100_0000 + k;
            #1;
            if (in_ready[1]) acc++;
            tick();
        end
        chk("t5_credits_restored", acc, 4);
        in_valid = 0;

`ifdef ARB_STATS_EN
        // 6: per-input packet counters and 16-bit wrap.
        do_reset();
        #1;
        chk("t6_cnt_reset", grant_cnt, 0);
        credit_in = 1'b1; in_tail = 4'hF;
        in_valid = 4'b1000;
        tick(); tick(); tick();
        in_valid = 4'b0001;
        tick(); in_valid = 0; #1;
        chk("t6_cnt3", grant_cnt[48 +: 16], 3);
        chk("t6_cnt0", grant_cnt[0 +: 16], 1);
        chk("t6_cnt1", grant_cnt[16 +: 16], 0);
        in_valid = 4'b0010;
        repeat (65535) tick();
        in_valid = 0; #1;
        chk("t6_cnt1_max", grant_cnt[16 +: 16], 16'hFFFF);
        in_valid = 4'b0010;
        tick(); in_valid = 0; #1;
        chk("t6_cnt1_wrap", grant_cnt[16 +: 16], 0);
        credit_in = 0; in_tail = 0;
`endif

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
